// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared types and defaults for the MSDAP serial word buffer
package msdap_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_ACK      = 2'd1,
    HS_WAIT_LOW = 2'd2
  } hs_state_t;

  localparam int ZERO_THRESH_DEF = 800;
  localparam int DEPTH_DEF       = 8;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo_fwft
  import msdap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  word_t                   i_wr_data,
  input  logic                    i_rd_en,
  output word_t                   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_fill_cnt
);

  localparam int AW = $clog2(DEPTH);

  word_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_empty;
  logic          w_do_wr;
  logic          w_do_rd;

  assign w_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  // A pop on an empty FIFO is ignored; a write into a full FIFO only goes in
  // when the head is leaving on the same edge.
  assign w_do_rd = i_rd_en && !w_empty;
  assign w_do_wr = i_wr_en && (!o_full || i_rd_en);

  assign o_rd_valid = !w_empty;
  assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_fill_cnt = r_cnt;

  // Storage array: no reset needed, the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clr && w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_buffer.sv
// rtl/serial_word_buffer.sv - handshake capture of serial input words into a FIFO with zero-run sleep detect
module serial_word_buffer
  import msdap_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ZERO_THRESH = ZERO_THRESH_DEF,
  parameter int CNT_W       = 10
) (
  input  logic                    dClk,
  input  logic                    reset,
  input  logic                    cntrl_rst,
  input  logic                    w_Ready,
  input  logic [15:0]             data_In,
  output logic                    ack,
  input  logic                    rd_En,
  output logic [15:0]             rd_Data,
  output logic                    rd_Valid,
  output logic [$clog2(DEPTH):0]  fill_Cnt,
  output logic                    overflow_Err,
  output logic                    sleep_Flag
);

  localparam logic [CNT_W-1:0] ZT = CNT_W'(ZERO_THRESH);

  hs_state_t        r_state;
  hs_state_t        w_next;
  logic             w_cap;
  logic             w_wr_en;
  logic             w_full;
  logic             r_ovf;
  logic [CNT_W-1:0] r_zero_cnt;
  logic [CNT_W-1:0] w_zero_nxt;
  logic             r_sleep;

  // Handshake state register; a controller clear behaves like reset at the edge.
  always_ff @(posedge dClk or negedge reset) begin
    if (!reset) begin
      r_state <= HS_IDLE;
    end else if (cntrl_rst) begin
      r_state <= HS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and decode: capture only from IDLE, ack is a pure state decode
  // so it falls the instant an asynchronous reset returns the FSM to IDLE.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    ack    = 1'b0;
    case (r_state)
      HS_IDLE: begin
        if (w_Ready) begin
          w_cap  = 1'b1;
          w_next = HS_ACK;
        end
      end
      HS_ACK: begin
        ack    = 1'b1;
        w_next = HS_WAIT_LOW;
      end
      HS_WAIT_LOW: begin
        if (!w_Ready) begin
          w_next = HS_IDLE;
        end
      end
      default: w_next = HS_IDLE;
    endcase
  end

  assign w_wr_en = w_cap && !cntrl_rst;

  sync_fifo_fwft #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (dClk),
    .i_rst_n    (reset),
    .i_clr      (cntrl_rst),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (data_In),
    .i_rd_en    (rd_En),
    .o_rd_data  (rd_Data),
    .o_rd_valid (rd_Valid),
    .o_full     (w_full),
    .o_fill_cnt (fill_Cnt)
  );

  // Sticky overflow: a capture found the FIFO full with no pop to make room.
  always_ff @(posedge dClk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (cntrl_rst) begin
      r_ovf <= 1'b0;
    end else if (w_cap && w_full && !rd_En) begin
      r_ovf <= 1'b1;
    end
  end

  // Zero-run count moves only on captures, dropped ones included.
  always_comb begin
    w_zero_nxt = r_zero_cnt;
    if (w_cap) begin
      if (data_In == 16'h0000) begin
        w_zero_nxt = (r_zero_cnt == ZT) ? ZT : r_zero_cnt + 1'b1;
      end else begin
        w_zero_nxt = '0;
      end
    end
  end

  // Counter and registered sleep flag update together so sleep tracks the capture edge.
  always_ff @(posedge dClk or negedge reset) begin
    if (!reset) begin
      r_zero_cnt <= '0;
      r_sleep    <= 1'b0;
    end else if (cntrl_rst) begin
      r_zero_cnt <= '0;
      r_sleep    <= 1'b0;
    end else begin
      r_zero_cnt <= w_zero_nxt;
      r_sleep    <= (w_zero_nxt == ZT);
    end
  end

  assign overflow_Err = r_ovf;
  assign sleep_Flag   = r_sleep;

endmodule

// File: tb/tb_serial_word_buffer.sv
// tb/tb_serial_word_buffer.sv - directed and randomized bench for serial_word_buffer
module tb_serial_word_buffer;
  import msdap_pkg::*;

  localparam int DEPTH = 8;
  localparam int ZT    = 800;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          dClk = 1'b0;
  logic          reset = 1'b0;
  logic          cntrl_rst = 1'b0;
  logic          w_Ready = 1'b0;
  logic [15:0]   data_In = 16'h0000;
  logic          ack;
  logic          rd_En = 1'b0;
  logic [15:0]   rd_Data;
  logic          rd_Valid;
  logic [FW-1:0] fill_Cnt;
  logic          overflow_Err;
  logic          sleep_Flag;

  serial_word_buffer #(
    .DEPTH(DEPTH),
    .ZERO_THRESH(ZT),
    .CNT_W(10)
  ) dut (
    .dClk         (dClk),
    .reset        (reset),
    .cntrl_rst    (cntrl_rst),
    .w_Ready      (w_Ready),
    .data_In      (data_In),
    .ack          (ack),
    .rd_En        (rd_En),
    .rd_Data      (rd_Data),
    .rd_Valid     (rd_Valid),
    .fill_Cnt     (fill_Cnt),
    .overflow_Err (overflow_Err),
    .sleep_Flag   (sleep_Flag)
  );

  always #5 dClk = ~dClk;

  // Reference model: the buffered words, sticky overflow, zero-run length,
  // whether a word is being acknowledged, and whether a new word may be taken.
  word_t m_q[$];
  bit    m_ovf;
  int    m_zero;
  bit    m_ack;
  bit    m_armed;
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_fail  = 0;
  int    n_ack   = 0;

  function automatic void m_clear();
    m_q.delete();
    m_ovf   = 1'b0;
    m_zero  = 0;
    m_ack   = 1'b0;
    m_armed = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    word_t hd;
    hd = (m_q.size() > 0) ? m_q[0] : 16'h0000;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rd_Valid", 32'(rd_Valid), 32'(m_q.size() > 0));
    chk("rd_Data", 32'(rd_Data), 32'(hd));
    chk("fill_Cnt", 32'(fill_Cnt), 32'(m_q.size()));
    chk("overflow_Err", 32'(overflow_Err), 32'(m_ovf));
    chk("sleep_Flag", 32'(sleep_Flag), 32'(m_zero == ZT));
  endtask

  // One clock: apply the rules at the rising edge, then compare at the falling edge.
  task automatic cyc();
    bit    prev_ack;
    bit    cap;
    bit    full;
    word_t tmp;
    @(posedge dClk);
    if (!reset || cntrl_rst) begin
      m_clear();
    end else begin
      prev_ack = m_ack;
      full     = (m_q.size() == DEPTH);
      cap      = w_Ready && m_armed;
      if (rd_En && m_q.size() > 0) tmp = m_q.pop_front();
      if (cap) begin
        if (!full || rd_En) m_q.push_back(data_In);
        else m_ovf = 1'b1;
        if (data_In == 16'h0000) begin
          if (m_zero < ZT) m_zero++;
        end else begin
          m_zero = 0;
        end
      end
      m_ack = cap;
      if (cap) m_armed = 1'b0;
      else if (!prev_ack && !w_Ready) m_armed = 1'b1;
    end
    @(negedge dClk);
    check_all();
    if (ack) n_ack++;
  endtask

  task automatic send_word(input word_t d, input int hold, input bit rd, input bit rnd);
    w_Ready = 1'b1;
    data_In = d;
    for (int i = 0; i < hold; i++) begin
      rd_En = rnd ? ($urandom_range(0, 3) == 0) : (i == 0 && rd);
      cyc();
    end
    w_Ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_En = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      cyc();
    end
    rd_En = 1'b0;
  endtask

  task automatic pop(input int n);
    rd_En = 1'b1;
    repeat (n) cyc();
    rd_En = 1'b0;
  endtask

  task automatic clear_pulse();
    cntrl_rst = 1'b1;
    cyc();
    cntrl_rst = 1'b0;
  endtask

  initial begin
    int    a0;
    word_t d;
    m_clear();
    repeat (2) @(negedge dClk);
    check_all();
    chk("reset_rd_Data", 32'(rd_Data), 32'h0);

    // Single word held three cycles: one capture, one ack pulse.
    reset = 1'b1;
    a0 = n_ack;
    send_word(16'h1234, 3, 1'b0, 1'b0);
    chk("single_ack_pulses", n_ack - a0, 1);
    chk("single_data", 32'(rd_Data), 32'h1234);
    chk("single_fill", 32'(fill_Cnt), 1);
    pop(1);

    // Fill to full, then a ninth word is dropped but still acknowledged.
    for (int k = 1; k <= 8; k++) send_word(16'(k), 1, 1'b0, 1'b0);
    a0 = n_ack;
    send_word(16'hDEAD, 1, 1'b0, 1'b0);
    chk("drop_ack", n_ack - a0, 1);
    chk("drop_ovf", 32'(overflow_Err), 1);
    chk("drop_fill", 32'(fill_Cnt), 8);
    pop(8);
    chk("drained_valid", 32'(rd_Valid), 0);

    // Full with a simultaneous pop: the ninth word goes in.
    clear_pulse();
    for (int k = 1; k <= 8; k++) send_word(16'(k), 1, 1'b0, 1'b0);
    send_word(16'h00AA, 1, 1'b1, 1'b0);
    chk("swap_fill", 32'(fill_Cnt), 8);
    chk("swap_ovf", 32'(overflow_Err), 0);
    pop(7);
    chk("swap_last", 32'(rd_Data), 32'h00AA);
    pop(1);

    // Zero run up to the threshold and back out.
    for (int k = 0; k < ZT - 1; k++) send_word(16'h0000, 1, 1'b1, 1'b0);
    chk("sleep_799", 32'(sleep_Flag), 0);
    w_Ready = 1'b1; data_In = 16'h0000; rd_En = 1'b1;
    cyc();
    chk("sleep_800", 32'(sleep_Flag), 1);
    w_Ready = 1'b0; rd_En = 1'b0;
    cyc(); cyc();
    w_Ready = 1'b1; data_In = 16'h0001;
    cyc();
    chk("sleep_cleared", 32'(sleep_Flag), 0);
    w_Ready = 1'b0;
    cyc(); cyc();

    // Build up sleep, overflow and three buffered words, then clear.
    for (int k = 0; k < ZT; k++) send_word(16'h0000, 1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) send_word(16'h0000, 1, 1'b0, 1'b0);
    pop(5);
    chk("pre_clr_sleep", 32'(sleep_Flag), 1);
    chk("pre_clr_ovf", 32'(overflow_Err), 1);
    chk("pre_clr_fill", 32'(fill_Cnt), 3);
    clear_pulse();
    chk("clr_valid", 32'(rd_Valid), 0);
    chk("clr_fill", 32'(fill_Cnt), 0);
    chk("clr_ovf", 32'(overflow_Err), 0);
    chk("clr_sleep", 32'(sleep_Flag), 0);
    send_word(16'h5555, 1, 1'b0, 1'b0);
    chk("post_clr_word", 32'(rd_Data), 32'h5555);
    pop(1);

    // Asynchronous reset while acknowledging.
    w_Ready = 1'b1; data_In = 16'h7777;
    cyc();
    chk("ack_before_reset", 32'(ack), 1);
    #2 reset = 1'b0;
    #1;
    m_clear();
    chk("async_ack_drop", 32'(ack), 0);
    check_all();
    w_Ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_reset_valid", 32'(rd_Valid), 0);
    send_word(16'h4321, 1, 1'b0, 1'b0);
    chk("post_reset_word", 32'(rd_Data), 32'h4321);

    // Randomized traffic with occasional controller clears.
    clear_pulse();
    for (int k = 0; k < 400; k++) begin
      d = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      send_word(d, $urandom_range(1, 3), 1'b0, 1'b1);
      if ($urandom_range(0, 49) == 0) clear_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_word_buffer.md
Name: serial_word_buffer

Overview:
- Stage directly downstream of the MSDAP serial input block.
- Captures each completed 16-bit word on the w_Ready/ack handshake and stores it in a small FIFO that the filter datapath drains.
- Also tracks runs of consecutive all-zero input words and raises a sleep indication for the controller.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, at least 2).
- ZERO_THRESH, 800, consecutive all-zero accepted words needed to assert sleep_Flag.
- CNT_W, 10, width of the zero-run counter (must satisfy 2^CNT_W > ZERO_THRESH).

Ports:
- dClk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cntrl_rst  input  1  synchronous clear from the controller; same effect as reset, applied at the next rising edge.
- w_Ready  input  1  upstream word-complete flag; level signal, stable at rising dClk.
- data_In  input  16  upstream word; valid while w_Ready=1.
- ack  output  1  one-cycle acknowledge to upstream.
- rd_En  input  1  pop request from the consumer.
- rd_Data  output  16  head-of-FIFO word, first-word-fall-through.
- rd_Valid  output  1  FIFO not empty.
- fill_Cnt  output  $clog2(DEPTH)+1  current occupancy.
- overflow_Err  output  1  sticky flag: a word was dropped.
- sleep_Flag  output  1  zero run has reached ZERO_THRESH.

Behaviour:
- Reset (reset=0, asynchronous) or cntrl_rst=1 (synchronous):
  - ack=0, rd_Valid=0, fill_Cnt=0, overflow_Err=0, sleep_Flag=0, rd_Data=16'h0000.
  - Pointers and zero counter cleared; FSM returns to IDLE.
  - Reset mid-handshake abandons the word; no ack is issued.
- Handshake FSM, three states:
  - IDLE: if w_Ready=1, the word is captured this edge, then next state is ACK. Otherwise remain in IDLE.
  - ACK: ack=1 for exactly this cycle, then go to WAIT_LOW.
  - WAIT_LOW: ack=0; stay until w_Ready=0, then go to IDLE. This guarantees each upstream word is taken exactly once.
- Capture rules:
  - If the FIFO is not full, or is full with rd_En=1 in the same cycle, data_In is written at the write pointer.
  - If the FIFO is full with rd_En=0, the word is dropped and overflow_Err is set. The flag stays set until reset or cntrl_rst.
  - A dropped word is still acknowledged.
- Latency:
  - w_Ready high at edge N: word written at N, ack high during cycle N+1.
  - rd_Valid and rd_Data reflect the new word from edge N.
- Read rules:
  - rd_En with rd_Valid=1 pops at the edge; rd_Data shows the next entry after that edge.
  - rd_En while empty is ignored: no pointer change, no error.
- Occupancy and pointers:
  - Simultaneous write and pop leaves fill_Cnt unchanged.
  - Pointers wrap modulo DEPTH.
  - fill_Cnt saturates logically at DEPTH (full) and 0 (empty).
- Zero run, updated only on accepted or dropped captures (not per clock):
  - A capture of data_In==0 increments the counter, saturating at ZERO_THRESH.
  - A capture of a nonzero word clears the counter to 0 at that edge.
  - sleep_Flag is registered: 1 when counter==ZERO_THRESH, so it asserts on the edge of the ZERO_THRESH-th zero word.
  - sleep_Flag deasserts on the edge that captures the first nonzero word.
  - Dropped words still count, because they are real input samples.

Decomposition:
- Package msdap_pkg:
  - typedef word_t (logic [15:0]).
  - FSM enum hs_state_t {HS_IDLE, HS_ACK, HS_WAIT_LOW}.
  - Default constants ZERO_THRESH_DEF=800 and DEPTH_DEF=8.
- One natural sub-module, sync_fifo_fwft: parameterised storage, pointers, fill_Cnt and full/empty.
- The handshake FSM, overflow flag and zero-run logic stay in serial_word_buffer.

Test Plan:
- Reset release then a single word: w_Ready=1 with data_In=16'h1234 held for 3 cycles -> exactly one ack pulse one cycle after capture; rd_Valid=1, rd_Data=16'h1234, fill_Cnt=1.
- Fill to full: write 8 words 1..8 with no reads, then a 9th word 16'hDEAD -> ack still pulses, overflow_Err=1, fill_Cnt=8; popping all 8 yields 1..8 in order, then rd_Valid=0.
- Full with simultaneous rd_En and w_Ready: 9th word 16'h00AA -> accepted, fill_Cnt stays 8, overflow_Err stays 0, last entry popped is 16'h00AA.
- Zero run: 799 zero words -> sleep_Flag=0. The 800th zero -> sleep_Flag=1 at its capture edge. Next word 16'h0001 -> sleep_Flag=0 and counter cleared.
- Mid-operation clear: 3 words buffered, sleep_Flag=1, overflow_Err=1, then cntrl_rst pulse -> all outputs at reset values next edge. A following word 16'h5555 is captured normally.
- Async reset during ACK state: reset pulled low mid-cycle -> ack drops immediately without waiting for a clock edge; after release with w_Ready=0, FSM is IDLE and rd_Valid=0.
